// File: rtl/wic_pkg.sv
// Shared state encoding and source index map for the wakeup interrupt controller.
package wic_pkg;

    typedef enum logic [1:0] {
        ST_OFF   = 2'd0,
        ST_ON    = 2'd1,
        ST_ARMED = 2'd2,
        ST_WAKE  = 2'd3
    } wic_state_t;

    localparam int unsigned SRC_NMI  = 0;
    localparam int unsigned SRC_RXEV = 1;
    localparam int unsigned IRQ_BASE = 2;

endpackage

// File: rtl/wic_src_cell.sv
// One wakeup source: mask bit, sticky pend bit, optional edge-select/prev (WIC_EDGE_DETECT_EN).
// Single-cycle sense latency; clear beats load beats accumulate.
module wic_src_cell
    import wic_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic load,
    input  logic arm,
    input  logic mask_in,
`ifdef WIC_EDGE_DETECT_EN
    input  logic edge_in,
`endif
    input  logic src,
    output logic mask,
    output logic pend
);

    logic mask_q, mask_d;
    logic pend_q, pend_d;
    logic hit;
`ifdef WIC_EDGE_DETECT_EN
    logic edge_q, edge_d;
    logic prev_q, prev_d;
`endif

    always_comb begin
        mask_d = mask_q;
        pend_d = pend_q;
`ifdef WIC_EDGE_DETECT_EN
        edge_d = edge_q;
        // prev tracks the source in every state so a pre-armed high level never fires
        prev_d = src;
        hit    = edge_q ? (src & ~prev_q) : src;
`else
        hit    = src;
`endif
        if (clear) begin
            mask_d = 1'b0;
            pend_d = 1'b0;
`ifdef WIC_EDGE_DETECT_EN
            edge_d = 1'b0;
`endif
        end else if (load) begin
            mask_d = mask_in;
`ifdef WIC_EDGE_DETECT_EN
            edge_d = edge_in;
`endif
        end else if (arm) begin
            pend_d = pend_q | (mask_q & hit);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mask_q <= 1'b0;
            pend_q <= 1'b0;
`ifdef WIC_EDGE_DETECT_EN
            edge_q <= 1'b0;
            prev_q <= 1'b0;
`endif
        end else begin
            mask_q <= mask_d;
            pend_q <= pend_d;
`ifdef WIC_EDGE_DETECT_EN
            edge_q <= edge_d;
            prev_q <= prev_d;
`endif
        end
    end

    assign mask = mask_q;
    assign pend = pend_q;

endmodule

// File: rtl/wic_ctrl_param.sv
// Parametrised WIC: arms a sense mask at sleep entry, latches events and raises WAKEUP.
// Event to WAKEUP is 2 FCLK edges; optional per-source edge sensing via WIC_EDGE_DETECT_EN.
module wic_ctrl_param
    import wic_pkg::*;
#(
    parameter int unsigned NUM_IRQ = 32
) (
    input  logic                 FCLK,
    input  logic                 PORESETn,
    input  logic                 WICENREQ,
    output logic                 WICENACK,
    input  logic                 WICLOAD,
    input  logic                 WICCLEAR,
    input  logic [NUM_IRQ+1:0]   WICMASK,
`ifdef WIC_EDGE_DETECT_EN
    input  logic [NUM_IRQ+1:0]   WICEDGE,
`endif
    input  logic                 NMI,
    input  logic                 RXEV,
    input  logic [NUM_IRQ-1:0]   IRQ,
    output logic [NUM_IRQ+1:0]   WICSENSE,
    output logic [NUM_IRQ+1:0]   WICPEND,
    output logic                 WAKEUP
);

    localparam int unsigned NUM_SRC = NUM_IRQ + 2;

    wic_state_t state_q, state_d;
    logic       ack_q, ack_d;
    logic       wakeup_q, wakeup_d;
    logic       clear, load, arm;
    logic [NUM_SRC-1:0] src_vec, mask_vec, pend_vec;

    assign src_vec[SRC_NMI]                = NMI;
    assign src_vec[SRC_RXEV]               = RXEV;
    assign src_vec[NUM_SRC-1:IRQ_BASE]     = IRQ;

    // Priority: enable drop > clear > load > new event
    always_comb begin
        state_d = state_q;
        clear   = 1'b0;
        load    = 1'b0;
        arm     = 1'b0;
        if (state_q == ST_OFF) begin
            if (WICENREQ) state_d = ST_ON;
        end else if (!WICENREQ) begin
            state_d = ST_OFF;
            clear   = 1'b1;
        end else if (WICCLEAR) begin
            state_d = ST_ON;
            clear   = 1'b1;
        end else if (state_q == ST_ON) begin
            if (WICLOAD) begin
                state_d = ST_ARMED;
                load    = 1'b1;
            end
        end else begin
            arm = 1'b1;
            if (state_q == ST_ARMED && |pend_vec) state_d = ST_WAKE;
        end
        ack_d    = (state_d != ST_OFF);
        wakeup_d = (state_d == ST_WAKE);
    end

    always_ff @(posedge FCLK) begin
        if (!PORESETn) begin
            state_q  <= ST_OFF;
            ack_q    <= 1'b0;
            wakeup_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            ack_q    <= ack_d;
            wakeup_q <= wakeup_d;
        end
    end

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        wic_src_cell u_cell (
            .clk     (FCLK),
            .rst_n   (PORESETn),
            .clear   (clear),
            .load    (load),
            .arm     (arm),
            .mask_in (WICMASK[i]),
`ifdef WIC_EDGE_DETECT_EN
            .edge_in (WICEDGE[i]),
`endif
            .src     (src_vec[i]),
            .mask    (mask_vec[i]),
            .pend    (pend_vec[i])
        );
    end

    assign WICENACK = ack_q;
    assign WAKEUP   = wakeup_q;
    assign WICSENSE = mask_vec;
    assign WICPEND  = pend_vec;

endmodule

// File: tb/tb_wic_ctrl_param.sv
// Directed self-checking bench for wic_ctrl_param (32-IRQ and 8-IRQ instances).
module tb_wic_ctrl_param;

    logic        fclk = 1'b0;
    always #5 fclk = ~fclk;

    int checks   = 0;
    int failures = 0;

    // 32-IRQ instance
    logic        rst_n, enreq, load, clear, nmi, rxev;
    logic [33:0] mask, edge_sel;
    logic [31:0] irq;
    logic        ack, wakeup;
    logic [33:0] sense, pend;

    // 8-IRQ instance
    logic        rst8_n, enreq8, load8, clear8, nmi8, rxev8;
    logic [9:0]  mask8, edge8;
    logic [7:0]  irq8;
    logic        ack8, wakeup8;
    logic [9:0]  sense8, pend8;

    wic_ctrl_param #(.NUM_IRQ(32)) dut (
        .FCLK(fclk), .PORESETn(rst_n), .WICENREQ(enreq), .WICENACK(ack),
        .WICLOAD(load), .WICCLEAR(clear), .WICMASK(mask),
`ifdef WIC_EDGE_DETECT_EN
        .WICEDGE(edge_sel),
`endif
        .NMI(nmi), .RXEV(rxev), .IRQ(irq),
        .WICSENSE(sense), .WICPEND(pend), .WAKEUP(wakeup)
    );

    wic_ctrl_param #(.NUM_IRQ(8)) dut8 (
        .FCLK(fclk), .PORESETn(rst8_n), .WICENREQ(enreq8), .WICENACK(ack8),
        .WICLOAD(load8), .WICCLEAR(clear8), .WICMASK(mask8),
`ifdef WIC_EDGE_DETECT_EN
        .WICEDGE(edge8),
`endif
        .NMI(nmi8), .RXEV(rxev8), .IRQ(irq8),
        .WICSENSE(sense8), .WICPEND(pend8), .WAKEUP(wakeup8)
    );

    task automatic tick();
        @(posedge fclk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; enreq = 0; load = 0; clear = 0; nmi = 0; rxev = 0;
        mask = '0; edge_sel = '0; irq = '0;
        rst8_n = 1'b0; enreq8 = 0; load8 = 0; clear8 = 0; nmi8 = 0; rxev8 = 0;
        mask8 = '0; edge8 = '0; irq8 = '0;
        tick(); tick();
        checks++;
        if ({ack, wakeup, sense, pend} !== '0) begin
            failures++;
            $display("FAIL reset: ack=%b wakeup=%b sense=%h pend=%h required all 0", ack, wakeup, sense, pend);
        end
        rst_n = 1'b1; rst8_n = 1'b1;
        tick();
    endtask

    task automatic test_enable_load();
        enreq = 1'b1;
        tick();
        checks++;
        if (ack !== 1'b1) begin
            failures++; $display("FAIL enable_ack: got %b required 1", ack);
        end
        mask = 34'h3_0000_0005; load = 1'b1;
        tick();
        load = 1'b0; mask = '0;
        checks++;
        if (sense !== 34'h3_0000_0005) begin
            failures++; $display("FAIL load_sense: got %h required 300000005", sense);
        end
        clear = 1'b1; tick(); clear = 1'b0;
        checks++;
        if (sense !== 34'h0) begin
            failures++; $display("FAIL clear_sense: got %h required 0", sense);
        end
    endtask

    task automatic test_irq_wake();
        mask = 34'h10; load = 1'b1; tick(); load = 1'b0;
        irq[2] = 1'b1; tick(); irq[2] = 1'b0;
        checks++;
        if (pend !== 34'h10 || wakeup !== 1'b0) begin
            failures++; $display("FAIL irq_edge1: pend=%h wakeup=%b required pend=10 wakeup=0", pend, wakeup);
        end
        tick();
        checks++;
        if (pend !== 34'h10 || wakeup !== 1'b1) begin
            failures++; $display("FAIL irq_edge2: pend=%h wakeup=%b required pend=10 wakeup=1", pend, wakeup);
        end
        tick(); tick(); tick();
        checks++;
        if (wakeup !== 1'b1) begin
            failures++; $display("FAIL wakeup_hold: got %b required 1", wakeup);
        end
        clear = 1'b1; tick(); clear = 1'b0;
        checks++;
        if (wakeup !== 1'b0 || pend !== 34'h0 || sense !== 34'h0) begin
            failures++; $display("FAIL irq_clear: wakeup=%b pend=%h sense=%h required 0", wakeup, pend, sense);
        end
    endtask

    task automatic test_rxev_only();
        mask = 34'h2; load = 1'b1; tick(); load = 1'b0;
        irq = '1; nmi = 1'b1;
        mask = 34'h4; load = 1'b1; tick(); load = 1'b0;
        checks++;
        if (sense !== 34'h2) begin
            failures++; $display("FAIL load_ignored_armed: sense=%h required 2", sense);
        end
        tick(); tick();
        checks++;
        if (pend !== 34'h0 || wakeup !== 1'b0) begin
            failures++; $display("FAIL unmasked_no_wake: pend=%h wakeup=%b required 0", pend, wakeup);
        end
        rxev = 1'b1; tick();
        checks++;
        if (pend !== 34'h2) begin
            failures++; $display("FAIL rxev_pend: got %h required 2", pend);
        end
        tick();
        checks++;
        if (wakeup !== 1'b1) begin
            failures++; $display("FAIL rxev_wakeup: got %b required 1", wakeup);
        end
        irq = '0; nmi = 1'b0; rxev = 1'b0;
        clear = 1'b1; tick(); clear = 1'b0;
    endtask

    task automatic test_clear_priority();
        mask = 34'h4; load = 1'b1; tick(); load = 1'b0;
        clear = 1'b1; irq[0] = 1'b1; tick(); clear = 1'b0; irq[0] = 1'b0;
        checks++;
        if (pend !== 34'h0 || sense !== 34'h0 || wakeup !== 1'b0) begin
            failures++; $display("FAIL clear_vs_event: pend=%h sense=%h wakeup=%b required 0", pend, sense, wakeup);
        end
        // A second load only takes effect if the clear returned to ON
        mask = 34'h4; load = 1'b1; tick(); load = 1'b0;
        checks++;
        if (sense !== 34'h4) begin
            failures++; $display("FAIL reload_after_clear: sense=%h required 4", sense);
        end
        irq[0] = 1'b1; tick(); tick(); irq[0] = 1'b0;
        checks++;
        if (wakeup !== 1'b1 || pend !== 34'h4) begin
            failures++; $display("FAIL irq0_wake: wakeup=%b pend=%h required 1/4", wakeup, pend);
        end
        enreq = 1'b0; tick();
        checks++;
        if (ack !== 1'b0 || wakeup !== 1'b0 || sense !== 34'h0 || pend !== 34'h0) begin
            failures++; $display("FAIL enreq_drop: ack=%b wakeup=%b sense=%h pend=%h required 0", ack, wakeup, sense, pend);
        end
        mask = 34'hFF; load = 1'b1; tick(); load = 1'b0;
        checks++;
        if (sense !== 34'h0 || ack !== 1'b0) begin
            failures++; $display("FAIL load_in_off: sense=%h ack=%b required 0", sense, ack);
        end
    endtask

    task automatic test_param8();
        enreq8 = 1'b1; tick();
        mask8 = 10'h3FF; load8 = 1'b1; tick(); load8 = 1'b0;
        irq8[7] = 1'b1; tick();
        checks++;
        if (pend8 !== 10'h200) begin
            failures++; $display("FAIL p8_pend: got %h required 200", pend8);
        end
        tick();
        checks++;
        if (wakeup8 !== 1'b1) begin
            failures++; $display("FAIL p8_wakeup: got %b required 1", wakeup8);
        end
        rst8_n = 1'b0; tick();
        checks++;
        if ({ack8, wakeup8, sense8, pend8} !== '0) begin
            failures++; $display("FAIL p8_reset: ack=%b wakeup=%b sense=%h pend=%h required 0", ack8, wakeup8, sense8, pend8);
        end
        rst8_n = 1'b1; irq8 = '0; enreq8 = 1'b0; tick();
    endtask

`ifdef WIC_EDGE_DETECT_EN
    task automatic test_edge();
        enreq = 1'b1; tick();
        irq[1] = 1'b1; tick();
        mask = 34'h8; edge_sel = 34'h8; load = 1'b1; tick(); load = 1'b0;
        tick(); tick();
        checks++;
        if (wakeup !== 1'b0 || pend !== 34'h0) begin
            failures++; $display("FAIL edge_level_high: wakeup=%b pend=%h required 0", wakeup, pend);
        end
        irq[1] = 1'b0; tick();
        irq[1] = 1'b1; tick();
        checks++;
        if (pend !== 34'h8) begin
            failures++; $display("FAIL edge_pend: got %h required 8", pend);
        end
        tick();
        checks++;
        if (wakeup !== 1'b1) begin
            failures++; $display("FAIL edge_wakeup: got %b required 1", wakeup);
        end
        irq[1] = 1'b0; clear = 1'b1; tick(); clear = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_enable_load();
        test_irq_wake();
        test_rxev_only();
        test_clear_priority();
        test_param8();
`ifdef WIC_EDGE_DETECT_EN
        test_edge();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/wic_ctrl_param.md
Name: wic_ctrl_param

Overview:
Parametrised Wakeup Interrupt Controller for the Cortex-M0 integration level. It runs on the free-running clock while the core is in deep sleep. The core loads a sense mask at sleep entry; any sensed NMI, RXEV or IRQ event latches pending and raises WAKEUP to the PMU. It generalises the fixed 34-bit WIC interface to NUM_IRQ lines and adds a readable pending vector for IRQ replay on wake.

Parameters:
NUM_IRQ, 32, number of IRQ inputs (1..240).
NUM_SRC, NUM_IRQ+2, derived and not overridable. Bit 0 is NMI, bit 1 is RXEV, bits [NUM_SRC-1:2] are IRQ[NUM_IRQ-1:0].

Ports:
FCLK  in  1  free-running clock
PORESETn  in  1  reset; one clock; reset is synchronous and active-low
WICENREQ  in  1  PMU request to enable the WIC
WICENACK  out  1  enable acknowledge
WICLOAD  in  1  single-cycle pulse from the core: capture WICMASK and arm
WICCLEAR  in  1  single-cycle pulse from the core: clear mask and pending, disarm
WICMASK  in  NUM_SRC  sense mask from the core's NVIC
NMI  in  1  non-maskable interrupt
RXEV  in  1  receive event
IRQ  in  NUM_IRQ  interrupt lines
WICSENSE  out  NUM_SRC  currently armed mask, to the PMU
WICPEND  out  NUM_SRC  latched pending events
WAKEUP  out  1  wake request to the PMU

Behaviour:
- Reset values: WICENACK=0, WICSENSE=0, WICPEND=0, WAKEUP=0, state=OFF. All outputs are registered.
- States: OFF, ON, ARMED, WAKE.
- OFF -> ON when WICENREQ=1. WICENACK rises in the same clock edge, so it is high 1 cycle after the request.
- In any state other than OFF, WICENREQ=0 -> OFF next edge. Mask, pending and WAKEUP clear on the same edge.
- ON -> ARMED on WICLOAD. The mask register takes WICMASK; WICSENSE = mask from the next cycle.
- WICLOAD in OFF, ARMED or WAKE is ignored.
- ARMED: every cycle, pend[i] |= mask[i] & src_hit[i]. src_hit is the level of the source (default build).
- ARMED -> WAKE when any pend bit is set. WAKEUP=1 one cycle after the event is sampled, so event-to-WAKEUP latency is 2 FCLK edges.
- In WAKE, pend stays sticky and keeps accumulating further masked events. WAKEUP holds until WICCLEAR.
- WICCLEAR in ARMED or WAKE clears mask, WICPEND and WAKEUP on the next edge and returns to ON.
- Priority on simultaneous inputs: WICENREQ drop > WICCLEAR > WICLOAD > new event. An event in the same cycle as WICCLEAR is dropped.
- Unmasked sources never set pend. NMI is only sensed when mask[0]=1; the core always sets that bit.
- A mask of all zeros arms the WIC but never wakes. This is legal.
- PORESETn asserted mid-operation returns every register to its reset value on the next edge.

Optional Feature:
WIC_EDGE_DETECT_EN.
- Defined: adds port WICEDGE (in, NUM_SRC) and a per-source previous-value register, reset 0.
- With WICEDGE[i]=1, src_hit[i] is a rising edge (cur & ~prev). Otherwise it is the level.
- The previous-value register also updates in OFF and ON, so a level already high at arm time does not fire.
- WICEDGE is captured into a register on WICLOAD, alongside the mask.
- Undefined: no WICEDGE port, and all sources are level-sensed.

Decomposition:
- Package wic_pkg holds:
  - the state encoding typedef (OFF=2'd0, ON=2'd1, ARMED=2'd2, WAKE=2'd3);
  - the source index constants SRC_NMI=0 and SRC_RXEV=1, with IRQ_BASE=2.
- Sub-module wic_src_cell: one per source, instantiated by a generate loop.
  - Contains the mask bit, the optional edge-select and prev registers, and the pend bit.
  - Inputs: clear, load and arm controls from the top-level FSM.

Test Plan:
1. WICENREQ=1 -> WICENACK=1 after 1 cycle. Then WICLOAD with WICMASK=0x3_0000_0005 -> WICSENSE=0x3_0000_0005 next cycle.
2. Armed with mask bit 4 set, pulse IRQ[2] for 1 cycle -> WICPEND=0x10 and WAKEUP=1 exactly 2 edges later. WAKEUP stays high until WICCLEAR, then 0 with WICPEND=0.
3. Armed with mask=0x2 (RXEV only): IRQ all high and NMI=1 -> no wake. RXEV=1 -> WICPEND=0x2 and WAKEUP=1.
4. WICCLEAR and IRQ[0] high in the same cycle -> WICPEND=0, state ON. WICENREQ drop while in WAKE -> WICENACK=0, WAKEUP=0, WICSENSE=0 next edge.
5. NUM_IRQ=8: arm with mask=0x3FF, assert IRQ[7] -> WICPEND=0x200. Also assert PORESETn low mid-WAKE -> all outputs 0 next edge.
6. With WIC_EDGE_DETECT_EN: WICEDGE bit 3 set and IRQ[1] already high at WICLOAD -> no wake. Drop IRQ[1] then raise it -> WAKEUP=1 with WICPEND=0x8.
